// File: rtl/mul_16x16_pkg.sv
// ============================================================================
// Module  : mul_pkg
// Brief   : Shared widths and types for the 16x16 unsigned multiplier core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;
  localparam int A_W    = 16;
  localparam int P_W    = 32;
  localparam int N_PP   = A_W;
  // Every 3:2 row removes one operand row, so 16 rows need 14 of them.
  localparam int N_CSA  = N_PP - 2;
  localparam int N_ROWS = N_PP + 2 * N_CSA;

  typedef logic [A_W-1:0] opnd_t;
  typedef logic [P_W-1:0] prod_t;
endpackage

`default_nettype wire

// File: rtl/mul_16x16_if.sv
// ============================================================================
// Module  : mul_16x16_if
// Brief   : Operand/product bundle of the multiplier core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_16x16_if;
  import mul_pkg::*;

  logic  in_valid;
  opnd_t a;
  opnd_t b;
  logic  out_valid;
  prod_t c;

  modport master (output in_valid, a, b, input out_valid, c);
  modport slave  (input in_valid, a, b, output out_valid, c);
endinterface

`default_nettype wire

// File: rtl/mul_16x16_csa_3to2.sv
// ============================================================================
// Module  : csa_3to2
// Brief   : N-bit carry-save row: three operands in, sum and shifted carry out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_3to2 #(
  parameter int N = 32
) (
  input  wire logic [N-1:0] i_x,
  input  wire logic [N-1:0] i_y,
  input  wire logic [N-1:0] i_z,
  output logic      [N-1:0] o_sum,
  output logic      [N-1:0] o_carry
);
  assign o_sum   = i_x ^ i_y ^ i_z;
  // Carry out of the MSB lies beyond the product width and is dropped.
  assign o_carry = {(i_x[N-2:0] & i_y[N-2:0]) |
                    (i_x[N-2:0] & i_z[N-2:0]) |
                    (i_y[N-2:0] & i_z[N-2:0]), 1'b0};
endmodule

`default_nettype wire

// File: rtl/mul_16x16.sv
// ============================================================================
// Module  : mul_16x16
// Brief   : Two-stage 16x16->32 unsigned multiplier (CSA tree, then final add).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_16x16
  import mul_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  mul_16x16_if.slave   bus
);
  prod_t w_row [N_ROWS];
  prod_t w_c;

  prod_t r_sum;
  prod_t r_carry;
  logic  r_vld1;
  prod_t r_c;
  logic  r_vld2;

  genvar gi;
  generate
    for (gi = 0; gi < N_PP; gi++) begin : g_pp
      assign w_row[gi] = bus.b[gi] ? (prod_t'(bus.a) << gi) : '0;
    end

    // Rows are consumed three at a time in creation order and each CSA appends
    // its sum/carry at the tail, giving a balanced reduction down to two rows.
    for (gi = 0; gi < N_CSA; gi++) begin : g_csa
      csa_3to2 #(.N(P_W)) u_csa (
        .i_x     (w_row[3*gi]),
        .i_y     (w_row[3*gi+1]),
        .i_z     (w_row[3*gi+2]),
        .o_sum   (w_row[N_PP+2*gi]),
        .o_carry (w_row[N_PP+2*gi+1])
      );
    end
  endgenerate

  assign w_c = r_sum + r_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_vld1  <= 1'b0;
      r_c     <= '0;
      r_vld2  <= 1'b0;
    end else begin
      r_sum   <= w_row[N_ROWS-2];
      r_carry <= w_row[N_ROWS-1];
      r_vld1  <= bus.in_valid;
      r_c     <= w_c;
      r_vld2  <= r_vld1;
    end
  end

  assign bus.c         = r_c;
  assign bus.out_valid = r_vld2;
endmodule

`default_nettype wire

// File: tb/tb_mul_16x16.sv
// ============================================================================
// Module  : tb_mul_16x16
// Brief   : Self-checking bench for mul_16x16: directed table plus random pairs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_16x16;
  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] e;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t pend [$];
  vec_t vecs [16];

  mul_16x16_if bus ();

  mul_16x16 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic v, input logic [31:0] c);
    n_cmp++;
    if (bus.out_valid !== v || bus.c !== c) begin
      n_err++;
      $display("FAIL %s: got out_valid=%0b c=0x%08h, want out_valid=%0b c=0x%08h",
               nm, bus.out_valid, bus.c, v, c);
    end
  endtask

  // The result visible after an edge is the pair driven two edges earlier.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] e, input string nm);
    exp_t x;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    x.v = v;
    x.c = e;
    pend.push_back(x);
    @(posedge clk);
    #1;
    if (pend.size() == 2) begin
      x = pend.pop_front();
      check(nm, x.v, x.c);
    end else begin
      check({nm, "_fill"}, 1'b0, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rv;

    vecs[0]  = '{1'b1, 16'd5,     16'd4,     32'd20};
    vecs[1]  = '{1'b1, 16'd7,     16'd3,     32'd21};
    vecs[2]  = '{1'b1, 16'd9,     16'd8,     32'd72};
    vecs[3]  = '{1'b1, 16'd256,   16'd256,   32'd65536};
    vecs[4]  = '{1'b1, 16'd1000,  16'd500,   32'd500000};
    vecs[5]  = '{1'b0, 16'd2300,  16'd3500,  32'd8050000};
    vecs[6]  = '{1'b1, 16'hFFFB,  16'd4,     32'd262124};
    vecs[7]  = '{1'b1, 16'd7,     16'hFFFD,  32'd458731};
    vecs[8]  = '{1'b1, 16'hFFF6,  16'hFFEC,  32'hFFE200C8};
    vecs[9]  = '{1'b1, 16'd0,     16'h1234,  32'd0};
    vecs[10] = '{1'b0, 16'hABCD,  16'd0,     32'd0};
    vecs[11] = '{1'b1, 16'hFFFF,  16'hFFFF,  32'hFFFE0001};
    vecs[12] = '{1'b1, 16'd1,     16'hBEEF,  32'h0000BEEF};
    vecs[13] = '{1'b1, 16'h8000,  16'd2,     32'h00010000};
    vecs[14] = '{1'b1, 16'hFFFF,  16'd1,     32'h0000FFFF};
    vecs[15] = '{1'b1, 16'h00FF,  16'h0101,  32'h0000FFFF};

    // Reset held across live edges with valid operands present.
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h5678;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      step(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++)
      step(1'b1, 16'd321, 16'd123, 32'd39483, "hold_stable");

    // Async reset mid-stream: outputs clear before the next edge.
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'd100 + 16'(i), 16'd3, 32'd300 + 32'(3 * i), "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 1'b0, 32'd0);
    pend.delete();
    @(posedge clk);
    #1;
    check("rst_held", 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'd12, 16'd13, 32'd156, "post_rst_first");
    step(1'b1, 16'd14, 16'd15, 32'd210, "post_rst_second");
    step(1'b0, 16'd2,  16'd2,  32'd4,   "post_rst_gap");

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      step(rv, ra, rb, 32'(ra) * 32'(rb), "random");
    end
    step(1'b0, 16'd0, 16'd0, 32'd0, "flush");
    step(1'b0, 16'd0, 16'd0, 32'd0, "flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
